// File: rtl/mux_arb_rr2.sv
// Two-requester round-robin arbiter driving a shared 2:1 data channel.
// The grant is registered; the mux select follows the registered grant so
// the data path never sees a combinational path from the request inputs.
// An owner that keeps requesting while the other side waits is preempted
// once it has held the channel for MAX_HOLD cycles.
//
//   state | meaning
//   ------+-----------------------------------------------
//   IDLE  | nobody owns the channel, out_data shows data_b
//   GNT_A | requester A owns the channel, sel = 1
//   GNT_B | requester B owns the channel, sel = 0
module mux_arb_rr2 #(
   parameter int NBITS    = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                          clk_2,
   input  logic                          reset,
   input  logic                          req_a,
   input  logic                          req_b,
   input  logic [NBITS-1:0]              data_a,
   input  logic [NBITS-1:0]              data_b,
   output logic                          gnt_a,
   output logic                          gnt_b,
   output logic                          sel,
   output logic [NBITS-1:0]              out_data,
   output logic                          out_valid,
   output logic                          last_grant,
   output logic [$clog2(MAX_HOLD)-1:0]   hold_cnt
);

   localparam int CNTW = $clog2(MAX_HOLD);
   localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_A = 2'd1,
      GNT_B = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_nxt_state;
   logic              r_gnt_a;
   logic              r_gnt_b;
   logic              r_last_grant;
   logic [CNTW-1:0]   r_hold_cnt;
   logic              w_hold_full;

   assign w_hold_full = (r_hold_cnt == HOLD_LAST);

   // Next-state decision: tie in IDLE goes to the side that did not own last,
   // an owner releases when it drops, and is preempted at the hold limit.
   always_comb begin
      w_nxt_state = r_state;
      case (r_state)
         IDLE: begin
            if (req_a && !req_b)
               w_nxt_state = GNT_A;
            else if (req_b && !req_a)
               w_nxt_state = GNT_B;
            else if (req_a && req_b)
               w_nxt_state = r_last_grant ? GNT_A : GNT_B;
            else
               w_nxt_state = IDLE;
         end
         GNT_A: begin
            if (!req_a)
               w_nxt_state = req_b ? GNT_B : IDLE;
            else if (req_b && w_hold_full)
               w_nxt_state = GNT_B;
            else
               w_nxt_state = GNT_A;
         end
         GNT_B: begin
            if (!req_b)
               w_nxt_state = req_a ? GNT_A : IDLE;
            else if (req_a && w_hold_full)
               w_nxt_state = GNT_A;
            else
               w_nxt_state = GNT_B;
         end
         default: w_nxt_state = IDLE;
      endcase
   end

   // Register state, grants, ownership history and the hold counter together.
   always_ff @(posedge clk_2 or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_gnt_a      <= 1'b0;
         r_gnt_b      <= 1'b0;
         r_last_grant <= 1'b1;
         r_hold_cnt   <= '0;
      end else begin
         r_state <= w_nxt_state;
         r_gnt_a <= (w_nxt_state == GNT_A);
         r_gnt_b <= (w_nxt_state == GNT_B);
         if (w_nxt_state == GNT_A && r_state != GNT_A)
            r_last_grant <= 1'b0;
         else if (w_nxt_state == GNT_B && r_state != GNT_B)
            r_last_grant <= 1'b1;
         // Fresh grant (including direct handover) restarts the count;
         // a held grant counts up and parks at the limit when unopposed.
         if (w_nxt_state == IDLE || w_nxt_state != r_state)
            r_hold_cnt <= '0;
         else if (!w_hold_full)
            r_hold_cnt <= r_hold_cnt + CNTW'(1);
      end
   end

   assign gnt_a      = r_gnt_a;
   assign gnt_b      = r_gnt_b;
   assign sel        = r_gnt_a;
   assign last_grant = r_last_grant;
   assign hold_cnt   = r_hold_cnt;
   assign out_data   = sel ? data_a : data_b;
   assign out_valid  = (r_gnt_a & req_a) | (r_gnt_b & req_b);

endmodule

// File: tb/tb_mux_arb_rr2.sv
// Bench for mux_arb_rr2: directed scenarios followed by random traffic,
// all compared against an ownership model kept as plain integers.
module tb_mux_arb_rr2;

   localparam int NBITS    = 8;
   localparam int MAX_HOLD = 4;
   localparam int CNTW     = $clog2(MAX_HOLD);

   logic              clk_2 = 1'b0;
   logic              reset = 1'b1;
   logic              req_a = 1'b0;
   logic              req_b = 1'b0;
   logic [NBITS-1:0]  data_a = '0;
   logic [NBITS-1:0]  data_b = '0;
   logic              gnt_a;
   logic              gnt_b;
   logic              sel;
   logic [NBITS-1:0]  out_data;
   logic              out_valid;
   logic              last_grant;
   logic [CNTW-1:0]   hold_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   // model: owner 0 = nobody, 1 = A, 2 = B; last 0 = A, 1 = B
   int m_owner = 0;
   int m_last  = 1;
   int m_held  = 0;

   mux_arb_rr2 #(.NBITS(NBITS), .MAX_HOLD(MAX_HOLD)) dut (
      .clk_2      (clk_2),
      .reset      (reset),
      .req_a      (req_a),
      .req_b      (req_b),
      .data_a     (data_a),
      .data_b     (data_b),
      .gnt_a      (gnt_a),
      .gnt_b      (gnt_b),
      .sel        (sel),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .last_grant (last_grant),
      .hold_cnt   (hold_cnt)
   );

   always #5 clk_2 = ~clk_2;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
   endtask

   task automatic model_reset();
      m_owner = 0;
      m_last  = 1;
      m_held  = 0;
   endtask

   // One clock edge of arbitration, phrased as "who owns the channel next".
   task automatic model_step(input bit ra, input bit rb);
      int  nxt;
      bit  want_own;
      bit  want_oth;
      int  other;
      if (m_owner == 0) begin
         if (ra && rb)      nxt = (m_last == 1) ? 1 : 2;
         else if (ra)       nxt = 1;
         else if (rb)       nxt = 2;
         else               nxt = 0;
      end else begin
         other    = 3 - m_owner;
         want_own = (m_owner == 1) ? ra : rb;
         want_oth = (m_owner == 1) ? rb : ra;
         if (!want_own)                              nxt = want_oth ? other : 0;
         else if (want_oth && m_held >= MAX_HOLD)    nxt = other;
         else                                        nxt = m_owner;
      end
      // m_held counts cycles of ownership (hold_cnt + 1, unsaturated)
      if (nxt == 0)              m_held = 0;
      else if (nxt != m_owner)   m_held = 1;
      else                       m_held = m_held + 1;
      if (nxt != 0 && nxt != m_owner) m_last = (nxt == 2) ? 1 : 0;
      m_owner = nxt;
   endtask

   task automatic check_all(input string where);
      int exp_hold;
      exp_hold = (m_owner == 0) ? 0 : ((m_held > MAX_HOLD) ? MAX_HOLD - 1 : m_held - 1);
      chk({where, ".gnt_a"},      32'(gnt_a),      32'(m_owner == 1));
      chk({where, ".gnt_b"},      32'(gnt_b),      32'(m_owner == 2));
      chk({where, ".sel"},        32'(sel),        32'(m_owner == 1));
      chk({where, ".out_data"},   32'(out_data),   32'((m_owner == 1) ? data_a : data_b));
      chk({where, ".out_valid"},  32'(out_valid),  32'((m_owner == 1 && req_a) || (m_owner == 2 && req_b)));
      chk({where, ".last_grant"}, 32'(last_grant), 32'(m_last));
      chk({where, ".hold_cnt"},   32'(hold_cnt),   32'(exp_hold));
   endtask

   // Advance one clock: model follows the edge, outputs compared mid-low phase.
   task automatic cyc(input string where);
      @(posedge clk_2);
      if (reset) model_reset();
      else model_step(req_a, req_b);
      @(negedge clk_2);
      check_all(where);
   endtask

   task automatic drive(input bit ra, input bit rb, input logic [NBITS-1:0] da,
                        input logic [NBITS-1:0] db, input string where);
      req_a  = ra;
      req_b  = rb;
      data_a = da;
      data_b = db;
      #1;
      check_all(where);
   endtask

   task automatic pulse_reset(input string where);
      #1;
      reset = 1'b1;
      #1;
      model_reset();
      check_all(where);
      @(negedge clk_2);
      reset = 1'b0;
      #1;
      check_all({where, "_rel"});
   endtask

   initial begin
      // power-on reset
      repeat (2) @(negedge clk_2);
      model_reset();
      check_all("por");
      reset = 1'b0;

      // single requester A, then release
      drive(1, 0, 8'hA5, 8'h00, "sa_raise");
      repeat (3) cyc("sa_hold");
      chk("sa_hold_cnt_lit", 32'(hold_cnt), 32'd2);
      drive(0, 0, 8'hA5, 8'h00, "sa_drop");
      chk("sa_valid_drop", 32'(out_valid), 32'd0);
      cyc("sa_idle");

      // tie from IDLE: A wins first, strict 4/4 alternation
      model_reset();
      pulse_reset("tie_rst");
      drive(1, 1, 8'h11, 8'h22, "tie_raise");
      cyc("tie_first");
      chk("tie_first_gnt_a", 32'(gnt_a), 32'd1);
      repeat (16) cyc("tie_alt");

      // saturation: A alone for 10 cycles, then B raises
      drive(0, 0, 8'h11, 8'h22, "sat_clear");
      cyc("sat_idle");
      drive(1, 0, 8'h5A, 8'h22, "sat_raise");
      repeat (10) cyc("sat_hold");
      chk("sat_cnt_lit", 32'(hold_cnt), 32'(MAX_HOLD - 1));
      drive(1, 1, 8'h5A, 8'h22, "sat_b_raise");
      cyc("sat_preempt");
      chk("sat_gnt_b_lit", 32'(gnt_b), 32'd1);

      // handover: in GNT_B, B drops while A raises
      drive(0, 1, 8'h81, 8'h3C, "ho_b_only");
      cyc("ho_b");
      chk("ho_data_b", 32'(out_data), 32'h3C);
      drive(1, 0, 8'h81, 8'h3C, "ho_swap");
      cyc("ho_a");
      chk("ho_data_a", 32'(out_data), 32'h81);
      chk("ho_cnt0", 32'(hold_cnt), 32'd0);

      // reset mid-grant in GNT_B with hold_cnt = 2, both still requesting
      drive(0, 0, 8'h81, 8'h3C, "rm_clear");
      cyc("rm_idle");
      drive(0, 1, 8'h81, 8'h3C, "rm_b");
      cyc("rm_b0");
      cyc("rm_b1");
      drive(1, 1, 8'h81, 8'h3C, "rm_both");
      cyc("rm_b2");
      chk("rm_cnt2", 32'(hold_cnt), 32'd2);
      pulse_reset("rm_rst");
      cyc("rm_after");
      chk("rm_after_gnt_a", 32'(gnt_a), 32'd1);

      // random traffic with occasional resets
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
               NBITS'($urandom), NBITS'($urandom), "rnd_drv");
         if ($urandom_range(0, 63) == 0)
            pulse_reset("rnd_rst");
         else
            cyc("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
